// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the slave memory model.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Per-beat response: decode error wins over a reserved burst type.
  function automatic logic [1:0] beat_resp(input logic dec, input logic [1:0] burst);
    if (dec)                 return RESP_DECERR;
    if (burst == BURST_RSVD) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for a full-width burst. FIXED holds the address;
// INCR and WRAP (treated as INCR) step by one bus width. The reserved type
// also steps, its beats are errored elsewhere.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SIZE_BYTES = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  // Select hold or step for the following beat.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    next_addr = addr;
    if (burst != BURST_FIXED) next_addr = addr + ADDR_W'(SIZE_BYTES);
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave memory model: INCR/FIXED bursts up to 16 beats, byte strobes,
// ID echo, independent read and write channels, one transaction per channel.
// Build option: define AXI_SLAVE_MEM_DECERR_EN to answer beats above the
// memory size with DECERR instead of aliasing.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 256
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Held low through reset so no ready is offered until reset is released.
  logic run;

  // Write channel
  w_state_t          w_state, w_state_nxt;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr, w_addr_nxt;
  logic [3:0]        w_len, w_count;
  logic [1:0]        w_burst;
  logic              w_slverr, w_decerr;
  logic              aw_hs, w_hs, w_beat_last, w_beat_dec;
  logic [IDX_W-1:0]  w_idx;

  // Read channel
  r_state_t          r_state, r_state_nxt;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr, r_addr_nxt;
  logic [3:0]        r_len, r_count;
  logic [1:0]        r_burst;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic              ar_hs, r_hs, ar_dec, r_nxt_dec;
  logic [IDX_W-1:0]  ar_idx, r_nxt_idx;

  axi_burst_addr #(.ADDR_W(ADDR_W), .SIZE_BYTES(STRB_W)) u_w_addr (
    .addr      (w_addr),
    .burst     (w_burst),
    .next_addr (w_addr_nxt)
  );

  axi_burst_addr #(.ADDR_W(ADDR_W), .SIZE_BYTES(STRB_W)) u_r_addr (
    .addr      (r_addr),
    .burst     (r_burst),
    .next_addr (r_addr_nxt)
  );

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign ar_hs       = arvalid && arready;
  assign r_hs        = rvalid && rready;
  assign w_beat_last = (w_count == w_len);
  assign w_idx       = w_addr[OFF_W +: IDX_W];
  assign ar_idx      = araddr[OFF_W +: IDX_W];
  assign r_nxt_idx   = r_addr_nxt[OFF_W +: IDX_W];

`ifdef AXI_SLAVE_MEM_DECERR_EN
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * STRB_W);
  assign w_beat_dec = ({1'b0, w_addr} >= MEM_BYTES);
  assign ar_dec     = ({1'b0, araddr} >= MEM_BYTES);
  assign r_nxt_dec  = ({1'b0, r_addr_nxt} >= MEM_BYTES);
`else
  assign w_beat_dec = 1'b0;
  assign ar_dec     = 1'b0;
  assign r_nxt_dec  = 1'b0;
`endif

  // Reset-release flag gating the ready outputs.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    run <= aresetn;
  end

  // ---------------- Write FSM ----------------

  // Write state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  // Write next-state: address, data beats, then hold the response.
  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_beat_last) w_state_nxt = W_RESP;
      W_RESP:  if (bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write channel outputs decoded from state and the sticky error flags.
  always_comb begin
    awready = run && (w_state == W_IDLE);
    wready  = run && (w_state == W_DATA);
    bvalid  = run && (w_state == W_RESP);
    bid     = w_id;
    if (w_decerr)      bresp = RESP_DECERR;
    else if (w_slverr) bresp = RESP_SLVERR;
    else               bresp = RESP_OKAY;
  end

  // Capture the write burst and track beat address, count and errors.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_id     <= '0;
      w_addr   <= '0;
      w_len    <= '0;
      w_burst  <= BURST_FIXED;
      w_count  <= '0;
      w_slverr <= 1'b0;
      w_decerr <= 1'b0;
    end else if (aw_hs) begin
      w_id     <= awid;
      w_addr   <= awaddr;
      w_len    <= awlen;
      w_burst  <= awburst;
      w_count  <= '0;
      w_slverr <= (awburst == BURST_RSVD);
      w_decerr <= 1'b0;
    end else if (w_hs) begin
      w_addr  <= w_addr_nxt;
      w_count <= w_count + 4'd1;
      if (wlast != w_beat_last) w_slverr <= 1'b1;
      if (w_beat_dec)           w_decerr <= 1'b1;
    end
  end

  // Byte-strobed memory write for accepted, non-errored beats.
  always_ff @(posedge aclk) begin
    // NOTE: the array has no reset branch; its contents survive reset and it maps onto plain RAM.
    if (aresetn && w_hs && !w_beat_dec && (w_burst != BURST_RSVD)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- Read FSM ----------------

  // Read state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  // Read next-state: stream beats until the last one is taken.
  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_last) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read channel outputs; payload comes straight from the beat registers.
  always_comb begin
    arready = run && (r_state == R_IDLE);
    rvalid  = run && (r_state == R_DATA);
    rid     = r_id;
    rdata   = r_data;
    rresp   = r_resp;
    rlast   = r_last;
  end

  // Load the first beat on AR and the next beat on each R handshake;
  // the payload is left untouched while the master stalls.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= BURST_FIXED;
      r_count <= '0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
      r_last  <= 1'b0;
    end else if (ar_hs) begin
      r_id    <= arid;
      r_addr  <= araddr;
      r_len   <= arlen;
      r_burst <= arburst;
      r_count <= '0;
      r_data  <= ar_dec ? '0 : mem[ar_idx];
      r_resp  <= beat_resp(ar_dec, arburst);
      r_last  <= (arlen == 4'd0);
    end else if (r_hs) begin
      if (r_last) begin
        r_last <= 1'b0;
      end else begin
        r_addr  <= r_addr_nxt;
        r_count <= r_count + 4'd1;
        r_data  <= r_nxt_dec ? '0 : mem[r_nxt_idx];
        r_resp  <= beat_resp(r_nxt_dec, r_burst);
        r_last  <= ((r_count + 4'd1) == r_len);
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: expected B and R beats are queued when
// a transaction is issued and compared as the slave returns them.
module tb_axi_slave_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 256;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] RSVD   = 2'b11;

`ifdef AXI_SLAVE_MEM_DECERR_EN
  localparam bit DECERR_ON = 1'b1;
`else
  localparam bit DECERR_ON = 1'b0;
`endif

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [ID_W-1:0]   awid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [3:0]        awlen, arlen;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] wbuf  [16];

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];

  axi_slave_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic beat_dec(input logic [31:0] a);
    return DECERR_ON && (a >= 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Issue a write burst; wlast is raised on beat last_beat, bready held off for b_delay cycles.
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [3:0] strb,
                             input int last_beat, input int b_delay);
    logic [31:0] a;
    logic        dec_any;
    logic        slv;
    bexp_t       e;
    int          cyc;
    a = addr;
    dec_any = 1'b0;
    slv = (burst == RSVD) || (last_beat != len);
    for (int i = 0; i <= len; i++) begin
      if (beat_dec(a)) dec_any = 1'b1;
      else if (burst != RSVD)
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[widx(a)][b*8 +: 8] = wbuf[i][b*8 +: 8];
      if (burst != FIXED) a = a + 32'd4;
    end
    e.id   = id;
    e.resp = dec_any ? DECERR : (slv ? SLVERR : OKAY);
    bq.push_back(e);

    awid = id; awaddr = addr; awlen = 4'(len); awburst = burst; awvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 20) begin step(); cyc++; end
    if (!awready) begin
      checks++; errors++;
      $display("FAIL aw_accept: awready stayed 0 for %0d cycles, required 1", cyc);
      awvalid = 1'b0; void'(bq.pop_back());
      return;
    end
    step();
    awvalid = 1'b0;

    for (int i = 0; i <= len; i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == last_beat); wvalid = 1'b1;
      cyc = 0;
      while (!wready && cyc < 20) begin step(); cyc++; end
      if (!wready) begin
        checks++; errors++;
        $display("FAIL w_accept: wready stayed 0 on beat %0d, required 1", i);
        wvalid = 1'b0; wlast = 1'b0; void'(bq.pop_back());
        return;
      end
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;

    cyc = 0;
    while (!bvalid && cyc < 20) begin step(); cyc++; end
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL b_timeout: bvalid stayed 0, required 1");
      void'(bq.pop_back());
      return;
    end
    e = bq.pop_front();
    for (int d = 0; d < b_delay; d++) begin
      step();
      checks++;
      if ({bvalid, bid, bresp} !== {1'b1, e.id, e.resp}) begin
        errors++;
        $display("FAIL b_hold: got valid=%0b id=%0h resp=%0d, required valid=1 id=%0h resp=%0d",
                 bvalid, bid, bresp, e.id, e.resp);
      end
    end
    checks++;
    if ({bid, bresp} !== {e.id, e.resp}) begin
      errors++;
      $display("FAIL b_resp: got id=%0h resp=%0d, required id=%0h resp=%0d", bid, bresp, e.id, e.resp);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL b_done: got bvalid=%0b after handshake, required 0", bvalid);
    end
  endtask

  // Issue a read burst; stall=1 drives rready with the repeating pattern 1,0,0,1.
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input bit stall);
    logic [31:0] a;
    rexp_t       e;
    int          cyc;
    int          got;
    logic        held;
    logic [31:0] held_data;
    logic        held_last;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      e.id   = id;
      e.data = beat_dec(a) ? 32'h0 : model[widx(a)];
      e.resp = beat_dec(a) ? DECERR : (burst == RSVD ? SLVERR : OKAY);
      e.last = (i == len);
      rq.push_back(e);
      if (burst != FIXED) a = a + 32'd4;
    end

    arid = id; araddr = addr; arlen = 4'(len); arburst = burst; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 20) begin step(); cyc++; end
    if (!arready) begin
      checks++; errors++;
      $display("FAIL ar_accept: arready stayed 0 for %0d cycles, required 1", cyc);
      arvalid = 1'b0; rq.delete();
      return;
    end
    step();
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL r_latency: got rvalid=%0b one cycle after AR, required 1", rvalid);
    end

    cyc = 0; got = 0; held = 1'b0; held_data = '0; held_last = 1'b0;
    while (got <= len && cyc < 200) begin
      rready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (rvalid) begin
        if (held) begin
          checks++;
          if ({rdata, rlast} !== {held_data, held_last}) begin
            errors++;
            $display("FAIL r_stable: got data=%08h last=%0b under stall, required data=%08h last=%0b",
                     rdata, rlast, held_data, held_last);
          end
        end
        if (rready) begin
          checks++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL r_extra: got unexpected beat data=%08h, required none", rdata);
          end else begin
            e = rq.pop_front();
            if ({rid, rdata, rresp, rlast} !== {e.id, e.data, e.resp, e.last}) begin
              errors++;
              $display("FAIL r_beat %0d: got id=%0h data=%08h resp=%0d last=%0b, required id=%0h data=%08h resp=%0d last=%0b",
                       got, rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
            end
          end
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1; held_data = rdata; held_last = rlast;
        end
      end
      step();
      cyc++;
    end
    rready = 1'b0;
    checks++;
    if (got <= len) begin
      errors++;
      $display("FAIL r_timeout: got %0d beats, required %0d", got, len + 1);
      rq.delete();
    end else if ({rvalid, arready} !== 2'b01) begin
      errors++;
      $display("FAIL r_idle: got rvalid=%0b arready=%0b after last beat, required rvalid=0 arready=1",
               rvalid, arready);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) step();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rdata, rresp} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got awready=%0b wready=%0b bvalid=%0b arready=%0b rvalid=%0b rlast=%0b rdata=%08h, required all 0",
               awready, wready, bvalid, arready, rvalid, rlast, rdata);
    end
    aresetn = 1'b1;
    step();
    checks++;
    if ({awready, arready, wready} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release: got awready=%0b arready=%0b wready=%0b, required 1 1 0",
               awready, arready, wready);
    end
    wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF;
    step();
    checks++;
    if (wready !== 1'b0) begin
      errors++;
      $display("FAIL w_before_aw: got wready=%0b with no AW, required 0", wready);
    end
    wvalid = 1'b0;
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    write_burst(4'h3, 32'h10, 3, INCR, 4'hF, 3, 2);
    read_burst(4'h6, 32'h10, 3, INCR, 1'b0);
  endtask

  task automatic test_strobe();
    wbuf[0] = 32'hFFFF_FFFF;
    write_burst(4'h1, 32'h20, 0, INCR, 4'hF, 0, 0);
    wbuf[0] = 32'h0000_00AB;
    write_burst(4'h2, 32'h20, 0, INCR, 4'b0001, 0, 0);
    read_burst(4'h3, 32'h20, 0, INCR, 1'b0);
  endtask

  task automatic test_read_stall();
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + 32'(i);
    write_burst(4'h4, 32'h100, 7, INCR, 4'hF, 7, 0);
    read_burst(4'h5, 32'h100, 7, INCR, 1'b1);
  endtask

  task automatic test_fixed();
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
    write_burst(4'h6, 32'h40, 2, FIXED, 4'hF, 2, 0);
    read_burst(4'h7, 32'h40, 0, INCR, 1'b0);
    read_burst(4'h8, 32'h40, 2, FIXED, 1'b0);
  endtask

  task automatic test_errors();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h8000 + 32'(i);
    write_burst(4'h8, 32'h80, 3, INCR, 4'hF, 1, 0);
    wbuf[0] = 32'hDEAD_BEEF;
    write_burst(4'h9, 32'h10, 0, RSVD, 4'hF, 0, 0);
    read_burst(4'h9, 32'h10, 0, INCR, 1'b0);
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + 32'(i);
    fork
      write_burst(4'hA, 32'h200, 3, INCR, 4'hF, 3, 0);
      read_burst(4'hB, 32'h10, 3, INCR, 1'b0);
    join
    read_burst(4'hC, 32'h200, 3, INCR, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    arid = 4'hE; araddr = 32'h100; arlen = 4'd7; arburst = INCR; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    step();
    aresetn = 1'b0;
    step();
    checks++;
    if ({rvalid, arready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_read: got rvalid=%0b arready=%0b in reset, required 0 0", rvalid, arready);
    end
    aresetn = 1'b1;
    step();
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_read_release: got arready=%0b, required 1", arready);
    end
    read_burst(4'hD, 32'h100, 1, INCR, 1'b0);
  endtask

  task automatic test_boundary();
    wbuf[0] = 32'h5555_0000;
    write_burst(4'h1, 32'h0, 0, INCR, 4'hF, 0, 0);
    wbuf[0] = 32'h3FC0_3FC0;
    write_burst(4'h2, 32'h3FC, 0, INCR, 4'hF, 0, 0);
    read_burst(4'h3, 32'h3FC, 1, INCR, 1'b0);
    wbuf[0] = 32'h0BAD_0400;
    write_burst(4'h4, 32'(DEPTH * 4), 0, INCR, 4'hF, 0, 0);
    read_burst(4'h5, 32'h0, 0, INCR, 1'b0);
    read_burst(4'h6, 32'(DEPTH * 4), 0, INCR, 1'b0);
  endtask

  initial begin
    test_reset();
    test_incr();
    test_strobe();
    test_read_stall();
    test_fixed();
    test_errors();
    test_concurrent();
    test_reset_mid_read();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
